// File: rtl/aes_inv_cipher_core.sv
// AES-128 iterative inverse cipher: ten key-expansion edges then ten decryption rounds.
// Forward and inverse S-boxes are computed arithmetically in GF(2^8) instead of from lookup tables.

package aes_inv_gf_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse; 0 maps to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    import aes_inv_gf_pkg::*;

    logic [7:0] b;

    assign b = gf_inv(a);
    assign d = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    import aes_inv_gf_pkg::*;

    logic [7:0] b;

    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign d = gf_inv(b);
endmodule

module aes_inv_cipher_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         done,
    output logic         busy,
    output logic [127:0] text_out
);
    import aes_inv_gf_pkg::*;

    typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] rk [0:10];
    logic [127:0] st;

    logic [127:0] rk_cur;
    logic [31:0]  w3_rot;
    logic [31:0]  w3_sub;
    logic [7:0]   rcon;
    logic [31:0]  ktmp;
    logic [31:0]  nk0, nk1, nk2, nk3;
    logic [127:0] nk;

    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    // rnd selects both the key being expanded and the round key being applied.
    assign rk_cur = rk[rnd];

    assign w3_rot = {rk_cur[23:0], rk_cur[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (.a(w3_rot[8*i +: 8]), .d(w3_sub[8*i +: 8]));
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign ktmp = w3_sub ^ {rcon, 24'h000000};
    assign nk0  = rk_cur[127:96] ^ ktmp;
    assign nk1  = rk_cur[95:64]  ^ nk0;
    assign nk2  = rk_cur[63:32]  ^ nk1;
    assign nk3  = rk_cur[31:0]   ^ nk2;
    assign nk   = {nk0, nk1, nk2, nk3};

    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign isr[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_inv_sub
        aes_inv_sbox u_inv_sbox (.a(isr[8*i +: 8]), .d(isb[8*i +: 8]));
    end

    assign ark = isb ^ rk_cur;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127 - 32*c -: 8];
        assign a1 = ark[119 - 32*c -: 8];
        assign a2 = ark[111 - 32*c -: 8];
        assign a3 = ark[103 - 32*c -: 8];
        assign imc[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign imc[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign imc[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign imc[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    // busy stays set through the done cycle; ld is gated by state alone so it is accepted then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rnd      <= 4'd0;
            done     <= 1'b0;
            busy     <= 1'b0;
            text_out <= 128'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        state <= KEXP;
                        rnd   <= 4'd0;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                KEXP: begin
                    if (rnd == 4'd9) begin
                        state <= DEC;
                        rnd   <= 4'd9;
                    end else begin
                        rnd   <= rnd + 4'd1;
                    end
                end
                DEC: begin
                    if (rnd == 4'd0) begin
                        text_out <= ark;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rnd      <= rnd - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (ld) begin
                    rk[0] <= key;
                    st    <= text_in;
                end
            end
            KEXP: begin
                rk[rnd + 4'd1] <= nk;
                if (rnd == 4'd9) st <= st ^ nk;
            end
            DEC: begin
                if (rnd != 4'd0) st <= imc;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/aes_inv_cipher_core.md
AES_INV_CIPHER_CORE -- requirements
Module: aes_inv_cipher_core

Interface
REQ-001 The block SHALL have no parameters; key length is fixed at AES-128 (Nr = 10).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ld  input  1  load strobe; sampled high in IDLE starts a decryption.
REQ-005 key  input  128  cipher key (FIPS-197 byte order, MSB = byte 0); sampled only on the accepted ld edge.
REQ-006 text_in  input  128  ciphertext block; sampled only on the accepted ld edge.
REQ-007 done  output  1  one-cycle pulse: text_out holds a new valid plaintext.
REQ-008 busy  output  1  high from the cycle after an accepted ld until the cycle done is asserted, inclusive.
REQ-009 text_out  output  128  plaintext result; registered.

Function
REQ-010 States SHALL be IDLE, KEXP and DEC, using a 4-bit round counter rnd.
REQ-011 IDLE with ld=1 at an edge SHALL capture key into rk[0] and text_in into the state register, set rnd=0, and go to KEXP.
REQ-012 In KEXP, each edge SHALL write rk[rnd+1] = KeyExpandRound(rk[rnd], Rcon[rnd+1]) and increment rnd, for 10 edges (rk[1]..rk[10]).
REQ-013 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36; SubWord SHALL use four instances of the codebase forward S-box (aes_sbox).
REQ-014 On the 10th KEXP edge the block SHALL also load state <= state XOR rk[10], using the combinationally computed next key, and go to DEC with rnd=9.
REQ-015 In DEC with rnd 9..1, each edge SHALL load state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[rnd]) and decrement rnd.
REQ-016 In DEC with rnd=0, the edge SHALL compute InvSubBytes(InvShiftRows(state)) XOR rk[0] with no InvMixColumns, load the result into text_out, set done=1, and return to IDLE.
REQ-017 InvSubBytes SHALL use 16 instances of the codebase inverse S-box (aes_inv_sbox); InvMixColumns SHALL use GF(2^8) multiplication by 0e/0b/0d/09 with reduction polynomial 0x11b.
REQ-018 Latency SHALL be exactly 20 clock edges from the ld-sampling edge to the edge that raises done (10 KEXP plus 10 DEC).
REQ-019 done SHALL be high for exactly one cycle; text_out SHALL hold its value until the next completion or reset.
REQ-020 ld asserted while busy=1 SHALL be ignored, with no restart and no change to the captured key or data.
REQ-021 ld asserted in the same cycle that done=1 SHALL be accepted, since the FSM is already in IDLE; back-to-back throughput SHALL be 21 cycles per block.
REQ-022 ld held high continuously SHALL start a new operation on each IDLE cycle and be ignored otherwise.
REQ-023 key and text_in changing while busy SHALL have no effect on the result.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, rnd=0, done=0, busy=0 and text_out=0, independent of clk.
REQ-025 rk[] and the state register need no reset value; they SHALL never reach outputs before being written.
REQ-026 Reset asserted mid-operation SHALL abort the operation: no done pulse follows, and the first ld after rst deasserts starts a clean decryption.
REQ-027 After rst deasserts, ld SHALL be honoured at the first clock edge.

Verification
REQ-028 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, text_in 3925841d02dc09fbdc118597196a0b32, ld 1 cycle -> done 20 edges later, text_out 3243f6a8885a308d313198a2e0370734.
REQ-029 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, text_in 69c4e0d86a7b0430d8cdb78070b4c55a -> text_out 00112233445566778899aabbccddeeff.
REQ-030 Round trip: encrypt key cafebabedeadbeefdeadbeef00000000, plaintext b4fde97f5fbfd5bc6ae980df7b110c5a with aes_cipher_top, feed its ciphertext with the same key -> text_out equals the original plaintext.
REQ-031 ld re-pulsed at edges 5 and 15 with different key and text_in -> both pulses ignored, REQ-028 result unchanged, busy stays high through done.
REQ-032 rst pulsed at edge 12 of an operation -> text_out=0, done never pulses; a subsequent ld of the REQ-029 vector -> correct result 20 edges later.
REQ-033 ld held high for 50 cycles with the REQ-028 vector -> done at edges 20 and 41, both with the correct plaintext.
